basic_fifo: RTL and testbench
=============================

// Module: basic_fifo
// PURPOSE
//  Synchronous single-clock FIFO with show-ahead (first-word-fall-through) read data.
//  Buffers DATA_WIDTH-bit words, e.g. decoded instructions in the issue queue ahead of the EXE dispatch.
//  Status flags feed back-pressure, e.g. almost_full stalls upstream fetch.
//  Synchronous clear flushes the queue, e.g. on a taken branch.
// PARAMETERS
//  ADDR_WIDTH             4   log2 of depth; DEPTH = 2**ADDR_WIDTH entries (power of two)
//  DATA_WIDTH             32  word width in bits
//  ALMOST_FULL_THRESHOLD  DEPTH-4  almost_full asserted when count >= this value
//  ALMOST_EMPTY_THRESHOLD 1   almost_empty asserted when count <= this value
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  clear         in   1           synchronous flush; discards all entries
//  push          in   1           write wr_data this cycle
//  pop           in   1           consume head entry this cycle
//  wr_data       in   DATA_WIDTH  data to enqueue
//  rd_data       out  DATA_WIDTH  head entry, valid combinationally whenever !empty
//  empty         out  1           count == 0
//  full          out  1           count == DEPTH
//  almost_empty  out  1           count <= ALMOST_EMPTY_THRESHOLD
//  almost_full   out  1           count >= ALMOST_FULL_THRESHOLD
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH); count (ADDR_WIDTH+1 bits).
//  - Storage is DEPTH x DATA_WIDTH registers/distributed RAM and is not reset.
//  - The write to mem[wr_ptr] is clocked.
//  - rd_data = mem[rd_ptr] combinationally (show-ahead).
//    - The consumer samples rd_data and asserts pop in the same cycle.
//  - Flags derive combinationally from count.
//    - Reset/clear values: empty=1, full=0, almost_empty=1.
//    - almost_full=0 unless ALMOST_FULL_THRESHOLD==0.
//  - rst or clear: next cycle wr_ptr=rd_ptr=count=0.
//    - rst has priority over clear; clear has priority over push/pop the same cycle.
//    - Both rst and clear drop any push/pop that cycle.
//  - Effective pop = pop && !empty.
//    - Pop on empty is ignored; no pointer or count change.
//  - Effective push = push && (!full || pop).
//    - A push on full with a simultaneous pop is accepted and count stays DEPTH.
//    - A push on full without a pop is dropped.
//  - Push and pop together on empty: the word is written; the pop is ignored; count becomes 1.
//  - Push and pop together when 0 < count < DEPTH: both pointers advance; count is unchanged.
//  - Newly pushed data is visible on rd_data the cycle after the push (no same-cycle bypass).
//  - rd_data is don't-care while empty.
//  - Pointers wrap DEPTH-1 -> 0 naturally; no other wrap handling is needed.
// CONFIGURATION
//  - BASIC_FIFO_CHECKS_EN defined:
//    - Simulation-only checks fire $error on push while full without pop (overflow).
//    - They also fire $error on pop while empty (underflow).
//    - An elaboration check rejects ALMOST_FULL_THRESHOLD > DEPTH.
//  - BASIC_FIFO_CHECKS_EN undefined: no checks; functional behaviour is identical.
// STRUCTURE
//  - Self-contained; no shared package typedefs are required.
//  - Callers pass $bits(<struct>) as DATA_WIDTH and cast rd_data.
//  - Optional sub-module: basic_fifo_mem (1 write port, 1 asynchronous read port, DEPTH x DATA_WIDTH).
//  - Pointer/count logic stays in basic_fifo.
// TESTING
//  1. After rst: empty=1, almost_empty=1, full=0, almost_full=0.
//     - pop asserted: no change.
//  2. Defaults (ADDR_WIDTH=4, AF=12): push 0x10..0x1B (12 words).
//     - almost_full rises after the 12th push; rd_data=0x10 throughout.
//     - Continue to 16 pushes -> full=1.
//     - A 17th push (no pop) is dropped.
//  3. From full: pop 16 times.
//     - rd_data sequence is 0x10..0x1F in order.
//     - empty=1 after the last pop; no extra entries.
//  4. Count=5: push+pop together for 20 cycles with values 0x100+i.
//     - count stays 5; read order is preserved across pointer wrap.
//  5. Count=7: assert clear together with push.
//     - Next cycle empty=1 and count=0.
//     - A following push 0xAB shows rd_data=0xAB one cycle later.
//  6. Full: push 0x55 with pop together.
//     - Head is popped; full stays 1.
//     - 0x55 emerges as the 16th subsequent read.

Source files
------------

// File: rtl/basic_fifo_pkg.sv
// Shared defaults and the push/pop operation decode for basic_fifo.
package basic_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Inputs are the already-qualified (effective) push and pop.
  function automatic fifo_op_e decode_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({push_ok, pop_ok});
  endfunction

endpackage

// File: rtl/basic_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one clocked write port, one asynchronous read port.
// Contents are deliberately not reset.
module basic_fifo_mem
  import basic_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/basic_fifo.sv
// Single-clock show-ahead FIFO; rd_data is the head combinationally, a push is visible next cycle.
// Push on full is dropped unless paired with a pop; BASIC_FIFO_CHECKS_EN adds overflow/underflow checks.
module basic_fifo
  import basic_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH             = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int ALMOST_FULL_THRESHOLD  = (2**ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push_ok, pop_ok, mem_wr_en;
  fifo_op_e              op;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);

  always_comb begin
    pop_ok    = pop && !empty;
    // A pop frees the slot this cycle, so a push on full still lands.
    push_ok   = push && (!full || pop);
    op        = decode_op(push_ok, pop_ok);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_wr_en = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          count_d   = count_q + CNT_ONE;
          mem_wr_en = 1'b1;
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          count_d  = count_q - CNT_ONE;
        end
        OP_BOTH: begin
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          mem_wr_en = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  basic_fifo_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (mem_wr_en && !rst),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

`ifdef BASIC_FIFO_CHECKS_EN
  if (ALMOST_FULL_THRESHOLD > 2**ADDR_WIDTH) begin : g_bad_af_threshold
    $error("basic_fifo: ALMOST_FULL_THRESHOLD exceeds DEPTH");
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      if (push && full && !pop) begin
        $error("basic_fifo: overflow, push while full without pop");
      end
      if (pop && empty) begin
        $error("basic_fifo: underflow, pop while empty");
      end
    end
  end
`else
  // Checks compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_basic_fifo.sv
// Scoreboard bench for basic_fifo at default parameters (depth 16, almost_full at 12).
module tb_basic_fifo;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst, clear, push, pop;
  logic [DW-1:0] wr_data, rd_data;
  logic          empty, full, almost_empty, almost_full;

  int            checks = 0;
  int            errors = 0;
  int            mcount = 0;
  logic [DW-1:0] sb [$];

  basic_fifo #(
    .ADDR_WIDTH            (AW),
    .DATA_WIDTH            (DW),
    .ALMOST_FULL_THRESHOLD (AF),
    .ALMOST_EMPTY_THRESHOLD(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push        (push),
    .pop         (pop),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_flags();
    return {mcount == 0, mcount <= AE, mcount == DEPTH, mcount >= AF};
  endfunction

  // Drives one cycle and advances the reference model and scoreboard.
  task automatic step(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
    logic pop_ok, push_ok;
    push = p; pop = q; clear = c; wr_data = d;
    @(posedge clk);
    #1;
    if (rst || c) begin
      mcount = 0;
      sb.delete();
    end else begin
      pop_ok  = q && (mcount > 0);
      push_ok = p && ((mcount < DEPTH) || q);
      if (pop_ok) begin
        sb.delete(0);
        mcount--;
      end
      if (push_ok) begin
        sb.push_back(d);
        mcount++;
      end
    end
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 32'hDEAD);
    rst = 1'b0;
    checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", {empty, almost_empty, full, almost_full}, 4'b1100);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({empty, almost_empty, full, almost_full} !== exp_flags()) begin
      errors++;
      $display("FAIL pop_on_empty: got %b expected %b", {empty, almost_empty, full, almost_full}, exp_flags());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h10 + DW'(i));
      checks++;
      if ({empty, almost_empty, full, almost_full} !== exp_flags()) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got %b expected %b", i, {empty, almost_empty, full, almost_full}, exp_flags());
      end
      checks++;
      if (rd_data !== 32'h10) begin
        errors++;
        $display("FAIL fill_head[%0d]: got %h expected %h", i, rd_data, 32'h10);
      end
    end
    step(1'b1, 1'b0, 1'b0, 32'hEE);
    checks++;
    if (full !== 1'b1 || rd_data !== 32'h10) begin
      errors++;
      $display("FAIL overflow_drop: got full=%b head=%h expected full=1 head=%h", full, rd_data, 32'h10);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (sb.size() == 0 || rd_data !== sb[0] || rd_data !== 32'h10 + DW'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got %h expected %h", i, rd_data, 32'h10 + DW'(i));
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      errors++;
      $display("FAIL drain_empty: got %b expected %b", {empty, almost_empty, full, almost_full}, 4'b1100);
    end
  endtask

  task automatic test_steady();
    logic [DW-1:0] exp;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h200 + DW'(i));
    for (int i = 0; i < 20; i++) begin
      exp = sb[0];
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL steady_head[%0d]: got %h expected %h", i, rd_data, exp);
      end
      step(1'b1, 1'b1, 1'b0, 32'h100 + DW'(i));
      checks++;
      if (mcount != 5 || {empty, almost_empty, full, almost_full} !== 4'b0000) begin
        errors++;
        $display("FAIL steady_flags[%0d]: got %b expected %b", i, {empty, almost_empty, full, almost_full}, 4'b0000);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_data !== 32'h100 + DW'(15 + i)) begin
        errors++;
        $display("FAIL steady_tail[%0d]: got %h expected %h", i, rd_data, 32'h100 + DW'(15 + i));
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL steady_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h300 + DW'(i));
    step(1'b1, 1'b0, 1'b1, 32'h99);
    checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      errors++;
      $display("FAIL clear_flags: got %b expected %b", {empty, almost_empty, full, almost_full}, 4'b1100);
    end
    step(1'b1, 1'b0, 1'b0, 32'hAB);
    checks++;
    if (empty !== 1'b0 || rd_data !== 32'hAB) begin
      errors++;
      $display("FAIL clear_then_push: got empty=%b head=%h expected empty=0 head=%h", empty, rd_data, 32'hAB);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL clear_single_entry: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 32'h400 + DW'(i));
    checks++;
    if (full !== 1'b1 || rd_data !== 32'h400) begin
      errors++;
      $display("FAIL full_setup: got full=%b head=%h expected full=1 head=%h", full, rd_data, 32'h400);
    end
    step(1'b1, 1'b1, 1'b0, 32'h55);
    checks++;
    if (full !== 1'b1 || rd_data !== 32'h401) begin
      errors++;
      $display("FAIL full_push_pop: got full=%b head=%h expected full=1 head=%h", full, rd_data, 32'h401);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (sb.size() == 0 || rd_data !== sb[0] || (i == DEPTH - 1 && rd_data !== 32'h55)) begin
        errors++;
        $display("FAIL full_drain[%0d]: got %h expected %h", i, rd_data, (i == DEPTH - 1) ? 32'h55 : 32'h401 + DW'(i));
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_drain_empty: got %b expected 1", empty);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_clear();
    test_full_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
